// File: rtl/spi_clk_divider.sv
// SPI master clock generator: programmable divide, glitch-free reconfiguration and stop, edge strobes.
// Define SPI_CLK_DIVIDER_EXT_CLK_EN to compile in the synchronized external clock source.

module spi_clk_divider #(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 axi_clk,
  input  logic                 axi_resetn,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] divide_factor,
  input  logic                 use_ext_spi_clk,
  input  logic                 cfg_load,
  input  logic                 ext_spi_clk,
  output logic                 master_spi_clk,
  output logic                 rise_strb,
  output logic                 fall_strb,
  output logic                 running,
  output logic                 busy,
  output logic [31:0]          edge_count
);

  typedef enum logic [1:0] {ST_STOPPED, ST_RUN, ST_PARK} state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] half_q, half_d;
  logic [DIV_WIDTH-1:0] pend_div_q, pend_div_d;
  logic                 clk_q, clk_d;
  logic                 busy_q, busy_d;
  logic                 rise_q, fall_q;
  logic [31:0]          edge_cnt_q;
  logic                 apply, pend_req;
  logic                 src_ext, ext_rise, ext_fall;

  function automatic logic [DIV_WIDTH-1:0] eff_half(input logic [DIV_WIDTH-1:0] f);
    return (f == '0) ? DIV_WIDTH'(1) : f;
  endfunction

`ifdef SPI_CLK_DIVIDER_EXT_CLK_EN
  logic       src_ext_q, src_ext_d;
  logic       pend_ext_q, pend_ext_d;
  logic [2:0] sync_q;

  // sync_q[1] is the synchronized level; sync_q[2] is its previous value for edge detection.
  assign ext_rise = sync_q[1] & ~sync_q[2];
  assign ext_fall = ~sync_q[1] & sync_q[2];
  assign src_ext  = src_ext_q;

  always_comb begin
    src_ext_d  = src_ext_q;
    pend_ext_d = pend_ext_q;
    if (apply) begin
      src_ext_d = cfg_load ? use_ext_spi_clk : pend_ext_q;
    end else if (cfg_load) begin
      pend_ext_d = use_ext_spi_clk;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      sync_q     <= '0;
      src_ext_q  <= 1'b0;
      pend_ext_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], ext_spi_clk};
      src_ext_q  <= src_ext_d;
      pend_ext_q <= pend_ext_d;
    end
  end
`else
  logic unused_ext;
  assign unused_ext = &{1'b0, ext_spi_clk, use_ext_spi_clk};
  assign src_ext    = 1'b0;
  assign ext_rise   = 1'b0;
  assign ext_fall   = 1'b0;
`endif

  assign pend_req = busy_q | cfg_load;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    clk_d      = clk_q;
    half_d     = half_q;
    pend_div_d = pend_div_q;
    busy_d     = busy_q;
    apply      = 1'b0;

    case (state_q)
      ST_STOPPED: begin
        clk_d = 1'b0;
        cnt_d = '0;
        apply = busy_q;
        if (enable) state_d = ST_RUN;
      end
      default: begin
        if (!clk_q && !enable) begin
          state_d = ST_STOPPED;
          cnt_d   = '0;
          apply   = busy_q;
        end else begin
          // A high phase always completes; enable only decides RUN versus PARK.
          state_d = enable ? ST_RUN : ST_PARK;
          if (src_ext) begin
            cnt_d = '0;
            if (ext_rise && !clk_q) begin
              if (pend_req) apply = 1'b1;
              else          clk_d = 1'b1;
            end else if (ext_fall && clk_q) begin
              clk_d = 1'b0;
            end
          end else if (cnt_q >= half_q - 1'b1) begin
            cnt_d = '0;
            if (clk_q)         clk_d = 1'b0;
            else if (pend_req) apply = 1'b1;
            else               clk_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase

    // Applying suppresses the rise, so the new config governs a full low phase from zero.
    if (apply) begin
      half_d = eff_half(cfg_load ? divide_factor : pend_div_q);
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (cfg_load) begin
      pend_div_d = divide_factor;
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q    <= ST_STOPPED;
      cnt_q      <= '0;
      clk_q      <= 1'b0;
      half_q     <= DIV_WIDTH'(DEFAULT_DIV);
      pend_div_q <= DIV_WIDTH'(DEFAULT_DIV);
      busy_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clk_q      <= clk_d;
      half_q     <= half_d;
      pend_div_q <= pend_div_d;
      busy_q     <= busy_d;
      rise_q     <= clk_d & ~clk_q;
      fall_q     <= ~clk_d & clk_q;
      edge_cnt_q <= edge_cnt_q + 32'(clk_d & ~clk_q);
    end
  end

  assign master_spi_clk = clk_q;
  assign rise_strb      = rise_q;
  assign fall_strb      = fall_q;
  assign running        = (state_q != ST_STOPPED);
  assign busy           = busy_q;
  assign edge_count     = edge_cnt_q;

endmodule
